// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider.
// Exports div_state_t, default widths and abs_val().
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Magnitude of the low w bits of v, read as two's
  // complement when sgn is set. MIN maps to 2^(w-1).
  function automatic logic [63:0] abs_val(
    input logic [63:0] v,
    input int unsigned w,
    input logic        sgn
  );
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    if (sgn && v[6'(w - 1)]) begin
      r = (~v + 64'd1) & mask;
    end else begin
      r = v & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Divider request/result bundle.
// master: execute-stage controller; slave: divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, a, b,
    input  quotient, remainder,
    input  done, busy, div_by_zero
  );

  modport slave (
    input  start, signed_mode, a, b,
    output quotient, remainder,
    output done, busy, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration.
// pr_i/msb_i/dvs_i in; pr_o (next rem), q_o out.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   pr_o,
  output logic             q_o
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] trial;

  // One spare bit keeps the trial sign exact
  // for divisors up to 2^WIDTH-1.
  assign sh    = {pr_i, msb_i};
  assign trial = sh - {2'b00, dvs_i};
  assign q_o   = ~trial[WIDTH+1];
  assign pr_o  = q_o ? trial[WIDTH:0] : sh[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, 1 quotient bit/clk.
// clk, reset (sync high), dif: seq_divider_if.slave.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave dif
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] bm_q, bm_d;
  logic             ngq_q, ngq_d;
  logic             ngr_q, ngr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   st_pr;
  logic             st_q;

  assign a_mag = WIDTH'(abs_val(64'(dif.a),
                        WIDTH, dif.signed_mode));
  assign b_mag = WIDTH'(abs_val(64'(dif.b),
                        WIDTH, dif.signed_mode));

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_i  (pr_q),
    .msb_i (dq_q[WIDTH-1]),
    .dvs_i (bm_q),
    .pr_o  (st_pr),
    .q_o   (st_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dq_d    = dq_q;
    bm_d    = bm_q;
    ngq_d   = ngq_q;
    ngr_d   = ngr_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        // busy_q still set here means this is the
        // done cycle: drop busy, refuse start.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (dif.start) begin
          busy_d = 1'b1;
          ngq_d  = dif.signed_mode &
                   (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
          ngr_d  = dif.signed_mode & dif.a[WIDTH-1];
          pr_d   = '0;
          bm_d   = b_mag;
          if (dif.b == '0) begin
            dz_d    = 1'b1;
            dq_d    = dif.a;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            dq_d    = a_mag;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        pr_d = st_pr;
        dq_d = {dq_q[WIDTH-2:0], st_q};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (dz_q) begin
          quo_d = '1;
          rem_d = dq_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = ngq_q ? -dq_q : dq_q;
          rem_d = ngr_q ? -pr_q[WIDTH-1:0]
                        :  pr_q[WIDTH-1:0];
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dq_q    <= '0;
      bm_q    <= '0;
      ngq_q   <= 1'b0;
      ngr_q   <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      bm_q    <= bm_d;
      ngq_q   <= ngq_d;
      ngr_q   <= ngr_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign dif.quotient    = quo_q;
  assign dif.remainder   = rem_q;
  assign dif.done        = done_q;
  assign dif.busy        = busy_q;
  assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH 32 and 8.
// Checks results, latency, busy/done and reset.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) d32();
  seq_divider_if #(.WIDTH(8))  d8();

  seq_divider #(.WIDTH(32)) u32 (
    .clk   (clk),
    .reset (reset),
    .dif   (d32)
  );

  seq_divider #(.WIDTH(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .dif   (d8)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic run32(
    input  logic        sm,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          poke,
    output int          lat,
    output int          bcnt
  );
    @(negedge clk);
    d32.start       = 1'b1;
    d32.signed_mode = sm;
    d32.a           = a;
    d32.b           = b;
    @(negedge clk);
    d32.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (d32.done !== 1'b1 && lat < 60) begin
      if (lat == poke) begin
        d32.start       = 1'b1;
        d32.signed_mode = ~sm;
        d32.a           = 32'd55;
        d32.b           = 32'd3;
      end else begin
        d32.start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (d32.busy) bcnt++;
    end
    d32.start = 1'b0;
  endtask

  task automatic run8(
    input  logic       sm,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output int         lat
  );
    @(negedge clk);
    d8.start       = 1'b1;
    d8.signed_mode = sm;
    d8.a           = a;
    d8.b           = b;
    @(negedge clk);
    d8.start = 1'b0;
    lat = 0;
    while (d8.done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [16:0] ref8(
    input logic       sm,
    input logic [7:0] a,
    input logic [7:0] b
  );
    int sa, sb;
    logic [7:0] q, r;
    if (b == 8'd0) return {1'b1, 8'hff, a};
    if (!sm) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end
    return {1'b0, q, r};
  endfunction

  logic [7:0] vals [12];
  int lat, bcnt, dcnt;

  initial begin
    vals = '{8'h00, 8'h01, 8'h02, 8'h03,
             8'h07, 8'h55, 8'h64, 8'h7f,
             8'h80, 8'h81, 8'hfe, 8'hff};
    d32.start = 0; d32.signed_mode = 0;
    d32.a = 0;     d32.b = 0;
    d8.start = 0;  d8.signed_mode = 0;
    d8.a = 0;      d8.b = 0;
    repeat (3) @(negedge clk);
    check("rst_out",
          {d32.quotient, d32.remainder},
          64'd0);
    check("rst_flags",
          {61'd0, d32.done, d32.busy,
           d32.div_by_zero}, 64'd0);
    reset = 1'b0;

    run32(1'b0, 32'd100, 32'd7, 5, lat, bcnt);
    check("u100_7", {d32.quotient, d32.remainder},
          {32'd14, 32'd2});
    check("u_lat", 64'(lat), 64'd34);
    check("u_busy", 64'(bcnt), 64'd34);
    check("u_dz", {63'd0, d32.div_by_zero}, 64'd0);
    @(negedge clk);
    check("done_pulse",
          {62'd0, d32.done, d32.busy}, 64'd0);
    @(negedge clk);
    check("poke_ignored",
          {62'd0, d32.done, d32.busy}, 64'd0);

    run32(1'b1, 32'hffffff9c, 32'd7, -1,
          lat, bcnt);
    check("s_m100_7", {d32.quotient, d32.remainder},
          {32'hfffffff2, 32'hfffffffe});
    check("s_lat", 64'(lat), 64'd34);
    repeat (2) @(negedge clk);

    run32(1'b1, 32'd100, 32'hfffffff9, -1,
          lat, bcnt);
    check("s_100_m7", {d32.quotient, d32.remainder},
          {32'hfffffff2, 32'd2});
    repeat (2) @(negedge clk);

    run32(1'b0, 32'h12345678, 32'd0, -1,
          lat, bcnt);
    check("dz_res", {d32.quotient, d32.remainder},
          {32'hffffffff, 32'h12345678});
    check("dz_flag", {63'd0, d32.div_by_zero}, 64'd1);
    check("dz_lat", 64'(lat), 64'd2);
    repeat (2) @(negedge clk);

    run32(1'b1, 32'h80000000, 32'hffffffff, -1,
          lat, bcnt);
    check("s_ovf", {d32.quotient, d32.remainder},
          {32'h80000000, 32'd0});
    check("s_ovf_dz", {63'd0, d32.div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);

    run32(1'b0, 32'h80000000, 32'hffffffff, -1,
          lat, bcnt);
    check("u_ovf", {d32.quotient, d32.remainder},
          {32'd0, 32'h80000000});
    repeat (2) @(negedge clk);

    d32.start = 1'b1; d32.signed_mode = 1'b0;
    d32.a = 32'd1000; d32.b = 32'd3;
    @(negedge clk);
    d32.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_out",
          {d32.quotient, d32.remainder}, 64'd0);
    check("rst_mid_flags",
          {61'd0, d32.done, d32.busy,
           d32.div_by_zero}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (d32.done) dcnt++;
    end
    check("rst_nodone", 64'(dcnt), 64'd0);

    run32(1'b0, 32'd1000, 32'd3, -1, lat, bcnt);
    check("post_rst", {d32.quotient, d32.remainder},
          {32'd333, 32'd1});
    check("post_lat", 64'(lat), 64'd34);
    repeat (2) @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          run8(m[0], vals[i], vals[j], lat);
          check($sformatf("w8 m%0d %0h/%0h",
                          m, vals[i], vals[j]),
                {47'd0, d8.div_by_zero,
                 d8.quotient, d8.remainder},
                {47'd0, ref8(m[0], vals[i],
                             vals[j])});
          check("w8_lat", 64'(lat),
                (vals[j] == 8'd0) ? 64'd2 : 64'd10);
          repeat (2) @(negedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
